// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer: state codes, opcodes and addrctl fields.
package microseq_pkg;

    localparam int CODE_W = 4;

    localparam logic [CODE_W-1:0] S_FETCH   = 4'd0;
    localparam logic [CODE_W-1:0] S_DECODE  = 4'd1;
    localparam logic [CODE_W-1:0] S_MEMADR  = 4'd2;
    localparam logic [CODE_W-1:0] S_MEMRD   = 4'd3;
    localparam logic [CODE_W-1:0] S_MEMWB   = 4'd4;
    localparam logic [CODE_W-1:0] S_MEMWR   = 4'd5;
    localparam logic [CODE_W-1:0] S_RTYPEEX = 4'd6;
    localparam logic [CODE_W-1:0] S_RTYPEWB = 4'd7;
    localparam logic [CODE_W-1:0] S_BEQEX   = 4'd8;
    localparam logic [CODE_W-1:0] S_JEX     = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] AC_FETCH = 2'b00;
    localparam logic [1:0] AC_DISP1 = 2'b01;
    localparam logic [1:0] AC_DISP2 = 2'b10;
    localparam logic [1:0] AC_SEQ   = 2'b11;

endpackage

// File: rtl/microseq_dispatch.sv
// Combinational dispatch ROMs: maps (sel, opcode) to a target state code.
// J is only a legal dispatch-1 target when MICROSEQ_JUMP_EN is defined.
module microseq_dispatch
    import microseq_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [5:0]        opcode,
    output logic [CODE_W-1:0] target,
    output logic              valid
);

    always_comb begin
        target = S_FETCH;
        valid  = 1'b0;
        case (sel)
            AC_DISP1: begin
                case (opcode)
                    OP_RTYPE: begin target = S_RTYPEEX; valid = 1'b1; end
                    OP_LW,
                    OP_SW:    begin target = S_MEMADR;  valid = 1'b1; end
                    OP_BEQ:   begin target = S_BEQEX;   valid = 1'b1; end
`ifdef MICROSEQ_JUMP_EN
                    OP_J:     begin target = S_JEX;     valid = 1'b1; end
`endif
                    default:  begin target = S_FETCH;   valid = 1'b0; end
                endcase
            end
            AC_DISP2: begin
                case (opcode)
                    OP_LW:   begin target = S_MEMRD; valid = 1'b1; end
                    OP_SW:   begin target = S_MEMWR; valid = 1'b1; end
                    default: begin target = S_FETCH; valid = 1'b0; end
                endcase
            end
            default: begin
                target = S_FETCH;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/microsequencer.sv
// Multicycle-CPU microprogram sequencer with registered inst_done/illegal pulses.
// Optional jump support is enabled by defining MICROSEQ_JUMP_EN.
//
//   state   | meaning
//   0 FETCH | fetch instruction
//   1 DECODE| decode, dispatch-1
//   2 MEMADR| address calc, dispatch-2
//   3 MEMRD | memory read
//   4 MEMWB | load writeback
//   5 MEMWR | memory write
//   6 RTYPEEX | ALU execute
//   7 RTYPEWB | ALU writeback
//   8 BEQEX | branch compare
//   9 JEX   | jump (unreachable without MICROSEQ_JUMP_EN)
module microsequencer
    import microseq_pkg::*;
#(
    parameter int STATE_W = 4
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         addrctl,
    input  logic [5:0]         opcode,
    input  logic               stall,
    output logic [STATE_W-1:0] state,
    output logic               inst_done,
    output logic               illegal
);

    localparam logic [STATE_W-1:0] ST_FETCH = STATE_W'(S_FETCH);
    localparam logic [STATE_W-1:0] ST_JEX   = STATE_W'(S_JEX);
    localparam logic [STATE_W-1:0] ST_ONE   = STATE_W'(1);

    logic [STATE_W-1:0] state_next;
    logic               bad_next;
    logic               inst_done_next;
    logic               illegal_next;
    logic               unreachable;
    logic [CODE_W-1:0]  disp_target;
    logic               disp_valid;

    microseq_dispatch u_dispatch (
        .sel    (addrctl),
        .opcode (opcode),
        .target (disp_target),
        .valid  (disp_valid)
    );

`ifdef MICROSEQ_JUMP_EN
    assign unreachable = (state > ST_JEX);
`else
    assign unreachable = (state >= ST_JEX);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            inst_done <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_next;
            inst_done <= inst_done_next;
            illegal   <= illegal_next;
        end
    end

    always_comb begin
        state_next = state;
        bad_next   = 1'b0;
        if (!stall) begin
            if (unreachable) begin
                state_next = ST_FETCH;
                bad_next   = 1'b1;
            end else begin
                case (addrctl)
                    AC_FETCH: state_next = ST_FETCH;
                    AC_SEQ: begin
                        // Sequencing past the last microinstruction wraps with an error.
                        if (state == ST_JEX) begin
                            state_next = ST_FETCH;
                            bad_next   = 1'b1;
                        end else begin
                            state_next = state + ST_ONE;
                        end
                    end
                    default: begin
                        if (disp_valid) begin
                            state_next = STATE_W'(disp_target);
                        end else begin
                            state_next = ST_FETCH;
                            bad_next   = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        inst_done_next = 1'b0;
        illegal_next   = 1'b0;
        if (!stall) begin
            inst_done_next = (state != ST_FETCH) && (state_next == ST_FETCH);
            illegal_next   = bad_next;
        end
    end

endmodule

// File: tb/tb_microsequencer.sv
// Directed table-driven bench for microsequencer plus stall and async-reset sequences.
module tb_microsequencer;

    localparam logic [1:0] F  = 2'b00;
    localparam logic [1:0] D1 = 2'b01;
    localparam logic [1:0] D2 = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BQ  = 6'b000100;
    localparam logic [5:0] JJ  = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct {
        logic [1:0] addrctl;
        logic [5:0] opcode;
        logic       stall;
        logic [3:0] exp_state;
        logic       exp_done;
        logic       exp_ill;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] addrctl;
    logic [5:0] opcode;
    logic       stall;
    logic [3:0] state;
    logic       inst_done;
    logic       illegal;

    int checks;
    int failures;
    vec_t vecs[$];

    microsequencer #(.STATE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addrctl   (addrctl),
        .opcode    (opcode),
        .stall     (stall),
        .state     (state),
        .inst_done (inst_done),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] a, input logic [5:0] op, input logic s,
                       input int st, input logic d, input logic il);
        vec_t v;
        v.addrctl   = a;
        v.opcode    = op;
        v.stall     = s;
        v.exp_state = st[3:0];
        v.exp_done  = d;
        v.exp_ill   = il;
        vecs.push_back(v);
    endtask

    // Drive inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic step(input logic [1:0] a, input logic [5:0] op, input logic s);
        addrctl = a;
        opcode  = op;
        stall   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input int st, input int d, input int il);
        chk({tag, ".state"}, int'(state), st);
        chk({tag, ".inst_done"}, int'(inst_done), d);
        chk({tag, ".illegal"}, int'(illegal), il);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        addrctl  = F;
        opcode   = RT;
        stall    = 1'b0;
        rst_n    = 1'b1;

        // LW: 0,1,2,3,4,0
        add(SQ, LW, 0, 1, 0, 0); add(D1, LW, 0, 2, 0, 0); add(D2, LW, 0, 3, 0, 0);
        add(SQ, LW, 0, 4, 0, 0); add(F,  LW, 0, 0, 1, 0);
        // SW: 0,1,2,5,0
        add(SQ, SW, 0, 1, 0, 0); add(D1, SW, 0, 2, 0, 0); add(D2, SW, 0, 5, 0, 0);
        add(F,  SW, 0, 0, 1, 0);
        // R-type: 0,1,6,7,0
        add(SQ, RT, 0, 1, 0, 0); add(D1, RT, 0, 6, 0, 0); add(SQ, RT, 0, 7, 0, 0);
        add(F,  RT, 0, 0, 1, 0);
        // BEQ, then sequence into 9 and dispatch from there
        add(SQ, BQ, 0, 1, 0, 0); add(D1, BQ, 0, 8, 0, 0); add(SQ, BQ, 0, 9, 0, 0);
`ifdef MICROSEQ_JUMP_EN
        add(D1, RT, 0, 6, 0, 0); add(SQ, RT, 0, 7, 0, 0); add(F, RT, 0, 0, 1, 0);
`else
        add(D1, RT, 0, 0, 1, 1);
`endif
        // illegal opcode at dispatch-1 and dispatch-2
        add(SQ, BAD, 0, 1, 0, 0); add(D1, BAD, 0, 0, 1, 1);
        add(SQ, BQ,  0, 1, 0, 0); add(D2, BQ,  0, 0, 1, 1);
        // illegal while already in FETCH: no inst_done
        add(D1, BAD, 0, 0, 0, 1);
        // stall in FETCH, then release with sequential
        add(SQ, RT, 1, 0, 0, 0); add(SQ, RT, 1, 0, 0, 0);
        add(SQ, RT, 0, 1, 0, 0); add(F, RT, 0, 0, 1, 0);
        // dispatch-2 from FETCH
        add(D2, LW, 0, 3, 0, 0); add(F, LW, 0, 0, 1, 0);
        // J
        add(SQ, JJ, 0, 1, 0, 0);
`ifdef MICROSEQ_JUMP_EN
        add(D1, JJ, 0, 9, 0, 0); add(SQ, JJ, 0, 0, 1, 1);
`else
        add(D1, JJ, 0, 0, 1, 1);
`endif

        // asynchronous reset with no clock edge in between
        #2 rst_n = 1'b0;
        #1;
        expect3("reset", 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect3("reset_hold", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            step(vecs[i].addrctl, vecs[i].opcode, vecs[i].stall);
            expect3($sformatf("vec%0d", i), int'(vecs[i].exp_state),
                    int'(vecs[i].exp_done), int'(vecs[i].exp_ill));
        end

        // stall three cycles at MEMRD; addrctl=00 must be ignored while stalled
        step(SQ, LW, 0); step(D1, LW, 0); step(D2, LW, 0);
        expect3("memrd", 3, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(F, BAD, 1);
            expect3($sformatf("stall%0d", k), 3, 0, 0);
        end
        step(SQ, LW, 0);
        expect3("unstall", 4, 0, 0);
        step(F, LW, 0);
        expect3("lw_done", 0, 1, 0);

        // async reset mid-instruction at RTYPEWB
        step(SQ, RT, 0); step(D1, RT, 0); step(SQ, RT, 0);
        expect3("at_rtypewb", 7, 0, 0);
        addrctl = F;
        #2 rst_n = 1'b0;
        #1;
        expect3("midreset", 0, 0, 0);
        @(posedge clk); #1;
        expect3("midreset_edge", 0, 0, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        addrctl = SQ;
        opcode  = RT;
        @(posedge clk); #1;
        expect3("post_reset", 1, 0, 0);
        step(F, RT, 0);
        expect3("post_reset_done", 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 SHALL have parameter STATE_W, default 4, width of the microprogram state/address.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port addrctl  input  2  sequencing field of the current microinstruction: 00 fetch, 01 dispatch-1, 10 dispatch-2, 11 sequential.
REQ-005 SHALL have port opcode  input  6  instruction opcode from the instruction register.
REQ-006 SHALL have port stall  input  1  memory not ready; hold the current state.
REQ-007 SHALL have port state  output  STATE_W  current microprogram address, driving the microprogram ROM.
REQ-008 SHALL have port inst_done  output  1  one-cycle pulse when an instruction's microcode returns to FETCH.
REQ-009 SHALL have port illegal  output  1  one-cycle pulse on an unsupported opcode or an unreachable state.

Function
REQ-010 SHALL use these state codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, JEX 9.
REQ-011 SHALL use these opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010.
REQ-012 SHALL register state and update it only on a rising clk edge; next state is combinational from state, addrctl and opcode.
REQ-013 SHALL set next state to FETCH when addrctl is 00.
REQ-014 SHALL set next state to state+1 when addrctl is 11.
REQ-015 Dispatch-1 (addrctl 01) SHALL map opcodes as follows: RTYPE->RTYPEEX, LW/SW->MEMADR, BEQ->BEQEX, J->JEX; any other opcode goes to FETCH and raises illegal.
REQ-016 Dispatch-2 (addrctl 10) SHALL map LW->MEMRD and SW->MEMWR; any other opcode goes to FETCH and raises illegal.
REQ-017 SHALL treat sequential from JEX (9) as wrap: next state FETCH, and raise illegal.
REQ-018 SHALL treat any current state 10..15 as unreachable: next state FETCH regardless of addrctl, and raise illegal.
REQ-019 SHALL pulse inst_done for exactly the cycle in which state transitions from a non-FETCH state to FETCH, including transitions caused by illegal.
REQ-020 SHALL hold state unchanged while stall=1 and keep inst_done and illegal at 0.
REQ-021 SHALL register inst_done and illegal, asserted in the same cycle the new state becomes visible.
REQ-022 When stall deasserts, SHALL evaluate the transition using the addrctl/opcode present in that cycle; stall SHALL have no memory of earlier cycles.

Reset
REQ-023 While rst_n=0, SHALL force state=FETCH, inst_done=0 and illegal=0 immediately, independent of clk.
REQ-024 Reset asserted mid-instruction SHALL abandon it without pulsing inst_done.
REQ-025 The first edge after rst_n rises SHALL evaluate normally from FETCH.

Configuration
REQ-026 Macro MICROSEQ_JUMP_EN: when defined, J dispatches to JEX; when undefined, J is illegal at dispatch-1 (goes to FETCH and pulses illegal), and JEX is treated as unreachable under REQ-018.

Structure
REQ-027 Package microseq_pkg SHALL hold the state code constants, the opcode constants and the addrctl encodings.
REQ-028 Sub-module microseq_dispatch SHALL hold both dispatch tables as pure combinational logic (inputs: sel and opcode; outputs: target and valid), instantiated once.

Verification
REQ-029 Reset, then drive the LW sequence (addrctl 11,01,10,11,00; opcode 100011) -> state 0,1,2,3,4,0; inst_done pulses once, on the return to 0.
REQ-030 SW sequence (opcode 101011) -> state 0,1,2,5,0; R-type sequence (opcode 000000) -> state 0,1,6,7,0.
REQ-031 Dispatch-1 with opcode 111111 at DECODE -> state 0; illegal=1 and inst_done=1 in the same cycle.
REQ-032 stall=1 for 3 cycles at MEMRD -> state stays 3 and no pulses; after stall drops, addrctl 11 -> state 4.
REQ-033 Assert rst_n=0 asynchronously mid-cycle at state 7 -> state reads 0 before the next clk edge; inst_done stays 0.
REQ-034 J opcode 000010 at DECODE -> state 9 with MICROSEQ_JUMP_EN defined; state 0 with illegal=1 when it is undefined.
